// File: rtl/dram_bank_cmd_sequencer.sv
// Single-request DRAM bank command sequencer: turns one frontend request into
// PRE/ACT/column commands with open-row tracking, and runs all-bank refresh.

package dram_bank_cmd_sequencer_pkg;
   typedef enum logic [2:0] {
      CMD_NOP, CMD_PRECHARGE, CMD_ACTIVE, CMD_READ, CMD_WRITE, CMD_REFRESH
   } cmd_type_t;

   typedef enum logic {BL_4, BL_8} burst_length_t;
   typedef enum logic {OP_READ, OP_WRITE} op_type_t;

   typedef struct packed {
      op_type_t    op_type;
      logic [2:0]  bank_addr;
      logic [12:0] row_addr;
      logic [9:0]  col_addr;
      logic [4:0]  req_id;
      logic [1:0]  core_num;
   } frontend_interconnection_request_t;

   typedef struct packed {
      cmd_type_t     cmd_type;
      burst_length_t burst_length;
      logic [2:0]    bank_addr;
      logic [13:0]   row_addr;
      logic [13:0]   col_addr;
   } bank_command_t;

   localparam bank_command_t NOP_CMD = '{cmd_type: CMD_NOP, burst_length: BL_4,
                                         bank_addr: '0, row_addr: '0, col_addr: '0};
endpackage

module dram_bank_cmd_sequencer
   import dram_bank_cmd_sequencer_pkg::*;
#(
   parameter int T_RP  = 4,
   parameter int T_RCD = 4,
   parameter int T_CCD = 2,
   parameter int T_RFC = 16
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              req_valid,
   output logic                              req_ready,
   input  frontend_interconnection_request_t req,
   output logic                              cmd_valid,
   input  logic                              cmd_ready,
   output bank_command_t                     cmd,
   output logic                              done_valid,
   output logic [4:0]                        done_id,
   output logic [1:0]                        done_core,
   input  logic                              ref_req,
   output logic                              ref_ack
);

   localparam int NUM_BANKS = 8;
   localparam int CW        = 8;

   typedef enum logic [3:0] {
      IDLE, ISSUE_PRE, WAIT_RP, ISSUE_ACT, WAIT_RCD, ISSUE_COL,
      REF_PRE, REF_WAIT_RP, REF_ISSUE, REF_WAIT_RFC
   } state_t;

   state_t                              state;
   frontend_interconnection_request_t   req_q;
   logic [NUM_BANKS-1:0]                open_q;
   logic [NUM_BANKS-1:0][12:0]          row_q;
   logic [CW-1:0]                       cnt;
   logic [CW-1:0]                       ccd_cnt;

   logic fire, col_fire, ccd_ok, cnt_last;

   function automatic bank_command_t mk_cmd(input cmd_type_t t, input burst_length_t bl,
                                            input logic [2:0] b, input logic [13:0] r,
                                            input logic [13:0] c);
      bank_command_t k;
      k.cmd_type     = t;
      k.burst_length = bl;
      k.bank_addr    = b;
      k.row_addr     = r;
      k.col_addr     = c;
      return k;
   endfunction

   function automatic bank_command_t pre_cmd(input frontend_interconnection_request_t q);
      return mk_cmd(CMD_PRECHARGE, BL_4, q.bank_addr, {1'b0, q.row_addr}, 14'd0);
   endfunction

   function automatic bank_command_t act_cmd(input frontend_interconnection_request_t q);
      return mk_cmd(CMD_ACTIVE, BL_4, q.bank_addr, {1'b0, q.row_addr}, 14'd0);
   endfunction

   function automatic bank_command_t col_cmd(input frontend_interconnection_request_t q);
      return mk_cmd((q.op_type == OP_READ) ? CMD_READ : CMD_WRITE, BL_8, q.bank_addr,
                    {1'b0, q.row_addr}, {4'd0, q.col_addr});
   endfunction

   assign req_ready = (state == IDLE) && !ref_req;
   assign fire      = cmd_valid && cmd_ready;
   assign col_fire  = fire && ((cmd.cmd_type == CMD_READ) || (cmd.cmd_type == CMD_WRITE));
   // Counters load T-1 on fire; the next command is registered while the count
   // reads 1 so that its valid first appears exactly T cycles after the fire.
   assign ccd_ok    = (ccd_cnt <= CW'(1));
   assign cnt_last  = (cnt <= CW'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         req_q      <= '0;
         open_q     <= '0;
         row_q      <= '0;
         cnt        <= '0;
         ccd_cnt    <= '0;
         cmd_valid  <= 1'b0;
         cmd        <= NOP_CMD;
         done_valid <= 1'b0;
         done_id    <= '0;
         done_core  <= '0;
         ref_ack    <= 1'b0;
      end else begin
         done_valid <= 1'b0;
         ref_ack    <= 1'b0;

         if (col_fire)           ccd_cnt <= CW'(T_CCD - 1);
         else if (ccd_cnt != '0) ccd_cnt <= ccd_cnt - CW'(1);

         case (state)
            IDLE: begin
               if (ref_req) begin
                  cmd_valid <= 1'b1;
                  if (|open_q) begin
                     state <= REF_PRE;
                     cmd   <= mk_cmd(CMD_PRECHARGE, BL_4, 3'd0, 14'd0, 14'h0400);
                  end else begin
                     state <= REF_ISSUE;
                     cmd   <= mk_cmd(CMD_REFRESH, BL_4, 3'd0, 14'd0, 14'd0);
                  end
               end else if (req_valid) begin
                  req_q <= req;
                  if (open_q[req.bank_addr] && (row_q[req.bank_addr] == req.row_addr)) begin
                     state <= ISSUE_COL;
                     if (ccd_ok) begin
                        cmd_valid <= 1'b1;
                        cmd       <= col_cmd(req);
                     end
                  end else if (open_q[req.bank_addr]) begin
                     state     <= ISSUE_PRE;
                     cmd_valid <= 1'b1;
                     cmd       <= pre_cmd(req);
                  end else begin
                     state     <= ISSUE_ACT;
                     cmd_valid <= 1'b1;
                     cmd       <= act_cmd(req);
                  end
               end
            end
            ISSUE_PRE: if (fire) begin
               open_q[req_q.bank_addr] <= 1'b0;
               cmd_valid <= 1'b0;
               cmd       <= NOP_CMD;
               cnt       <= CW'(T_RP - 1);
               state     <= WAIT_RP;
            end
            WAIT_RP: begin
               if (cnt_last) begin
                  cmd_valid <= 1'b1;
                  cmd       <= act_cmd(req_q);
                  state     <= ISSUE_ACT;
               end else cnt <= cnt - CW'(1);
            end
            ISSUE_ACT: if (fire) begin
               open_q[req_q.bank_addr] <= 1'b1;
               row_q[req_q.bank_addr]  <= req_q.row_addr;
               cmd_valid <= 1'b0;
               cmd       <= NOP_CMD;
               cnt       <= CW'(T_RCD - 1);
               state     <= WAIT_RCD;
            end
            WAIT_RCD: begin
               if (cnt_last) begin
                  state <= ISSUE_COL;
                  if (ccd_ok) begin
                     cmd_valid <= 1'b1;
                     cmd       <= col_cmd(req_q);
                  end
               end else cnt <= cnt - CW'(1);
            end
            ISSUE_COL: begin
               if (cmd_valid && cmd_ready) begin
                  cmd_valid  <= 1'b0;
                  cmd        <= NOP_CMD;
                  done_valid <= 1'b1;
                  done_id    <= req_q.req_id;
                  done_core  <= req_q.core_num;
                  state      <= IDLE;
               end else if (!cmd_valid && ccd_ok) begin
                  cmd_valid <= 1'b1;
                  cmd       <= col_cmd(req_q);
               end
            end
            REF_PRE: if (fire) begin
               open_q    <= '0;
               cmd_valid <= 1'b0;
               cmd       <= NOP_CMD;
               cnt       <= CW'(T_RP - 1);
               state     <= REF_WAIT_RP;
            end
            REF_WAIT_RP: begin
               if (cnt_last) begin
                  cmd_valid <= 1'b1;
                  cmd       <= mk_cmd(CMD_REFRESH, BL_4, 3'd0, 14'd0, 14'd0);
                  state     <= REF_ISSUE;
               end else cnt <= cnt - CW'(1);
            end
            REF_ISSUE: if (fire) begin
               cmd_valid <= 1'b0;
               cmd       <= NOP_CMD;
               cnt       <= CW'(T_RFC - 1);
               state     <= REF_WAIT_RFC;
            end
            REF_WAIT_RFC: begin
               if (cnt_last) begin
                  ref_ack <= 1'b1;
                  open_q  <= '0;
                  state   <= IDLE;
               end else cnt <= cnt - CW'(1);
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dram_bank_cmd_sequencer.sv
// Bench for dram_bank_cmd_sequencer: directed scenarios plus random requests
// checked against an open-row table model and expected command lists.

module tb_dram_bank_cmd_sequencer;
   import dram_bank_cmd_sequencer_pkg::*;

   localparam int T_RP = 4, T_RCD = 4, T_CCD = 2, T_RFC = 16;

   logic clk = 1'b0;
   logic rst_n;
   logic req_valid, req_ready, cmd_valid, cmd_ready, done_valid, ref_req, ref_ack;
   frontend_interconnection_request_t req;
   bank_command_t cmd;
   logic [4:0] done_id;
   logic [1:0] done_core;

   always #5 clk = ~clk;

   dram_bank_cmd_sequencer #(.T_RP(T_RP), .T_RCD(T_RCD), .T_CCD(T_CCD), .T_RFC(T_RFC)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req(req),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd), .done_valid(done_valid),
      .done_id(done_id), .done_core(done_core), .ref_req(ref_req), .ref_ack(ref_ack)
   );

   typedef struct { int c; bank_command_t bc; } ev_t;

   int total = 0, bad = 0, cyc = 0;
   ev_t fires[$];
   int  pres[$], done_c[$], done_idq[$], done_coreq[$], ack_c[$];
   int  acc_c;
   int  ready_mode, hold_left;
   logic hold_used, prev_valid, prev_fire;
   bank_command_t prev_cmd;
   logic open_m[8];
   int   row_m[8];
   int   last_col;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic frontend_interconnection_request_t mkreq(
      input op_type_t op, input logic [2:0] b, input logic [12:0] r, input logic [9:0] c,
      input logic [4:0] id, input logic [1:0] core);
      frontend_interconnection_request_t q;
      q.op_type = op; q.bank_addr = b; q.row_addr = r; q.col_addr = c;
      q.req_id = id; q.core_num = core;
      return q;
   endfunction

   // One clock cycle: set cmd_ready, observe this cycle's outputs, advance.
   task automatic step();
      logic acc, fire;
      if (ref_ack) ref_req = 1'b0;
      #1;
      case (ready_mode)
         0: cmd_ready = 1'b1;
         1: cmd_ready = ($urandom_range(0, 2) != 0);
         default: begin
            if (cmd_valid && cmd.cmd_type == CMD_ACTIVE && !hold_used) begin
               hold_used = 1'b1; hold_left = 5;
            end
            if (hold_left > 0) begin cmd_ready = 1'b0; hold_left--; end
            else cmd_ready = 1'b1;
         end
      endcase
      #1;
      if (prev_valid && !prev_fire) begin
         chk("hold_valid", 64'(cmd_valid), 64'(1'b1));
         chk("hold_cmd", 64'(cmd), 64'(prev_cmd));
      end
      if (!cmd_valid) chk("nop_when_idle", 64'(cmd), 64'(NOP_CMD));
      if (cmd_valid && (!prev_valid || prev_fire)) pres.push_back(cyc);
      fire = cmd_valid && cmd_ready;
      if (fire) fires.push_back('{c: cyc, bc: cmd});
      if (done_valid) begin
         done_c.push_back(cyc); done_idq.push_back(int'(done_id)); done_coreq.push_back(int'(done_core));
      end
      if (ref_ack) ack_c.push_back(cyc);
      acc = req_valid && req_ready;
      if (acc) acc_c = cyc;
      prev_valid = cmd_valid; prev_fire = fire; prev_cmd = cmd;
      @(posedge clk); #1;
      cyc++;
      if (acc) req_valid = 1'b0;
   endtask

   task automatic clear_logs();
      fires.delete(); pres.delete(); done_c.delete(); done_idq.delete();
      done_coreq.delete(); ack_c.delete(); acc_c = -1;
   endtask

   // Runs an optional refresh and/or one request, then checks every command,
   // its timing, done/ack pulses and updates the open-row model.
   task automatic do_txn(input string tag, input logic do_ref, input logic do_req,
                         input frontend_interconnection_request_t r, input int mode);
      logic any_open, exp_pre;
      int kind, n_exp, k, budget, pre_f, act_f, ref_f, col_f;
      any_open = 1'b0;
      for (int i = 0; i < 8; i++) any_open |= open_m[i];
      exp_pre = do_ref && any_open;
      if (do_ref) for (int i = 0; i < 8; i++) open_m[i] = 1'b0;
      kind = 2;
      if (open_m[r.bank_addr] && row_m[r.bank_addr] == int'(r.row_addr)) kind = 0;
      else if (open_m[r.bank_addr]) kind = 1;
      n_exp = (do_ref ? (exp_pre ? 2 : 1) : 0) + (do_req ? ((kind == 0) ? 1 : (kind == 1) ? 3 : 2) : 0);

      clear_logs();
      ready_mode = mode; hold_used = 1'b0; hold_left = 0;
      ref_req = do_ref; req = r; req_valid = do_req;
      if (do_ref && do_req) begin
         #1;
         chk({tag, "_ref_blocks_req"}, 64'(req_ready), 64'(1'b0));
      end
      for (budget = 0; budget < 300; budget++) begin
         step();
         if ((!do_req || done_c.size() > 0) && (!do_ref || ack_c.size() > 0)) break;
      end
      chk({tag, "_finished"}, 64'(budget < 300), 64'(1'b1));
      step(); step();
      ref_req = 1'b0; req_valid = 1'b0;

      chk({tag, "_nfires"}, 64'(fires.size()), 64'(n_exp));
      chk({tag, "_npres"}, 64'(pres.size()), 64'(n_exp));
      if (fires.size() != n_exp || pres.size() != n_exp) return;
      k = 0; pre_f = 0; act_f = 0; ref_f = 0;
      if (do_ref) begin
         if (exp_pre) begin
            chk({tag, "_refpre_type"}, 64'(fires[k].bc.cmd_type), 64'(CMD_PRECHARGE));
            chk({tag, "_refpre_all"}, 64'(fires[k].bc.col_addr[10]), 64'(1'b1));
            chk({tag, "_refpre_bank"}, 64'(fires[k].bc.bank_addr), 64'(0));
            pre_f = fires[k].c; k++;
         end
         chk({tag, "_ref_type"}, 64'(fires[k].bc.cmd_type), 64'(CMD_REFRESH));
         if (exp_pre) chk({tag, "_ref_trp"}, 64'(pres[k]), 64'(pre_f + T_RP));
         ref_f = fires[k].c; k++;
         chk({tag, "_nack"}, 64'(ack_c.size()), 64'(1));
         if (ack_c.size() == 1) chk({tag, "_ack_trfc"}, 64'(ack_c[0]), 64'(ref_f + T_RFC));
      end else chk({tag, "_no_ack"}, 64'(ack_c.size()), 64'(0));

      if (do_req) begin
         if (kind == 1) begin
            chk({tag, "_pre_type"}, 64'(fires[k].bc.cmd_type), 64'(CMD_PRECHARGE));
            chk({tag, "_pre_bank"}, 64'(fires[k].bc.bank_addr), 64'(r.bank_addr));
            pre_f = fires[k].c; k++;
         end
         if (kind != 0) begin
            chk({tag, "_act_type"}, 64'(fires[k].bc.cmd_type), 64'(CMD_ACTIVE));
            chk({tag, "_act_bank"}, 64'(fires[k].bc.bank_addr), 64'(r.bank_addr));
            chk({tag, "_act_row"}, 64'(fires[k].bc.row_addr), 64'(r.row_addr));
            chk({tag, "_act_col0"}, 64'(fires[k].bc.col_addr), 64'(0));
            if (kind == 1) chk({tag, "_act_trp"}, 64'(pres[k]), 64'(pre_f + T_RP));
            act_f = fires[k].c; k++;
         end
         chk({tag, "_col_type"}, 64'(fires[k].bc.cmd_type),
             64'((r.op_type == OP_READ) ? CMD_READ : CMD_WRITE));
         chk({tag, "_col_bank"}, 64'(fires[k].bc.bank_addr), 64'(r.bank_addr));
         chk({tag, "_col_addr"}, 64'(fires[k].bc.col_addr), 64'(r.col_addr));
         chk({tag, "_col_bl8"}, 64'(fires[k].bc.burst_length), 64'(BL_8));
         if (kind != 0) chk({tag, "_col_trcd"}, 64'(pres[k]), 64'(act_f + T_RCD));
         chk({tag, "_col_tccd"}, 64'(pres[k] >= last_col + T_CCD), 64'(1'b1));
         chk({tag, "_col_after_acc"}, 64'(pres[k] > acc_c && acc_c >= 0), 64'(1'b1));
         col_f = fires[k].c;
         last_col = col_f;
         chk({tag, "_ndone"}, 64'(done_c.size()), 64'(1));
         if (done_c.size() == 1) begin
            chk({tag, "_done_cyc"}, 64'(done_c[0]), 64'(col_f + 1));
            chk({tag, "_done_id"}, 64'(done_idq[0]), 64'(r.req_id));
            chk({tag, "_done_core"}, 64'(done_coreq[0]), 64'(r.core_num));
         end
         open_m[r.bank_addr] = 1'b1;
         row_m[r.bank_addr]  = int'(r.row_addr);
      end else chk({tag, "_no_done"}, 64'(done_c.size()), 64'(0));
   endtask

   initial begin
      frontend_interconnection_request_t r;
      logic dr, dq;
      rst_n = 1'b0; req_valid = 1'b0; cmd_ready = 1'b0; ref_req = 1'b0; req = '0;
      prev_valid = 1'b0; prev_fire = 1'b0; prev_cmd = NOP_CMD; last_col = -100;
      ready_mode = 0; hold_used = 1'b0; hold_left = 0; acc_c = -1;
      for (int i = 0; i < 8; i++) begin open_m[i] = 1'b0; row_m[i] = 0; end
      #1;
      chk("rst_cmd_valid", 64'(cmd_valid), 64'(1'b0));
      chk("rst_cmd", 64'(cmd), 64'(NOP_CMD));
      chk("rst_done", 64'({done_valid, done_id, done_core}), 64'(0));
      chk("rst_ref_ack", 64'(ref_ack), 64'(1'b0));
      @(posedge clk); #1; rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_req_ready", 64'(req_ready), 64'(1'b1));

      do_txn("t1_closed", 1'b0, 1'b1, mkreq(OP_READ, 3'd2, 13'd5, 10'd8, 5'd3, 2'd1), 0);
      do_txn("t2_hit", 1'b0, 1'b1, mkreq(OP_READ, 3'd2, 13'd5, 10'd16, 5'd4, 2'd2), 0);
      do_txn("t3_miss", 1'b0, 1'b1, mkreq(OP_WRITE, 3'd2, 13'd9, 10'd3, 5'd5, 2'd0), 0);
      do_txn("t3_row9_hit", 1'b0, 1'b1, mkreq(OP_READ, 3'd2, 13'd9, 10'd4, 5'd6, 2'd3), 0);
      do_txn("t4_backpr", 1'b0, 1'b1, mkreq(OP_WRITE, 3'd5, 13'd1, 10'd1023, 5'd31, 2'd3), 2);
      do_txn("t5_refresh", 1'b1, 1'b1, mkreq(OP_READ, 3'd2, 13'd9, 10'd7, 5'd9, 2'd1), 0);

      // Reset while waiting out tRCD: nothing may complete afterwards.
      clear_logs(); ready_mode = 0;
      req = mkreq(OP_READ, 3'd3, 13'd7, 10'd1, 5'd21, 2'd3); req_valid = 1'b1;
      for (int i = 0; i < 20 && fires.size() == 0; i++) step();
      chk("t6_act_fired", 64'(fires.size()), 64'(1));
      step(); step();
      rst_n = 1'b0; #1;
      chk("t6_cmd_valid", 64'(cmd_valid), 64'(1'b0));
      chk("t6_cmd", 64'(cmd), 64'(NOP_CMD));
      chk("t6_done", 64'({done_valid, done_id, done_core}), 64'(0));
      chk("t6_ref_ack", 64'(ref_ack), 64'(1'b0));
      #4; rst_n = 1'b1;
      @(posedge clk); #1; cyc++;
      chk("t6_req_ready", 64'(req_ready), 64'(1'b1));
      for (int i = 0; i < 8; i++) open_m[i] = 1'b0;
      last_col = -100; prev_valid = 1'b0; prev_fire = 1'b0;
      clear_logs();
      repeat (12) step();
      chk("t6_no_cmd", 64'(fires.size()), 64'(0));
      chk("t6_no_done", 64'(done_c.size()), 64'(0));

      do_txn("ref_all_closed", 1'b1, 1'b0, mkreq(OP_READ, 3'd0, 13'd0, 10'd0, 5'd0, 2'd0), 0);

      for (int n = 0; n < 60; n++) begin
         dr = ($urandom_range(0, 6) == 0);
         dq = !dr || ($urandom_range(0, 1) == 1);
         r = mkreq(op_type_t'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                   13'($urandom_range(0, 2)), 10'($urandom_range(0, 1023)),
                   5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)));
         do_txn("rand", dr, dq, r, int'($urandom_range(0, 1)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
